// File: rtl/sum_accumulator.sv
// Accumulates a programmed number of adder results into a wide running total.
// Optional SUM_ACCUMULATOR_SATURATE_EN clamps the total to all ones instead of wrapping.
module sum_accumulator #(
  parameter int unsigned IN_W  = 5,
  parameter int unsigned ACC_W = 12,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, out_valid_q, busy_q;
  logic [SUM_W-1:0]   sum;
  logic [CNT_W-1:0]   cnt_inc;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    sum     = {1'b0, acc_q} + SUM_W'(in_data);
    cnt_inc = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          len_d   = len;
          state_d = (len == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid && in_ready_q) begin
          acc_d = sum[ACC_W-1:0];
          ovf_d = ovf_q | sum[ACC_W];
`ifdef SUM_ACCUMULATOR_SATURATE_EN
          if (sum[ACC_W]) acc_d = '1;
`endif
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == ACCUM);
      out_valid_q <= (state_d == HOLD);
      busy_q      <= (state_d == ACCUM) || (state_d == HOLD);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = acc_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: a 12-bit and an 8-bit instance share stimulus.
module tb_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [7:0]  len;
  logic [4:0]  in_data;
  logic        in_ready, out_valid, busy, overflow;
  logic [11:0] out_data;
  logic        in_ready8, out_valid8, busy8, overflow8;
  logic [7:0]  out_data8;

  int checks = 0;
  int errors = 0;

`ifdef SUM_ACCUMULATOR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int m_acc, m8_acc;
  bit m_ovf, m8_ovf;
  int q_data[$];
  bit q_ovf[$];
  int q8_data[$];
  bit q8_ovf[$];

  always #5 clk = ~clk;

  sum_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .overflow(overflow)
  );

  sum_accumulator #(.IN_W(5), .ACC_W(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
    .busy(busy8), .overflow(overflow8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_add(input int d);
    int s;
    s = m_acc + d;
    if (s > 4095) begin m_ovf = 1'b1; m_acc = SAT ? 4095 : (s & 4095); end
    else m_acc = s;
    s = m8_acc + d;
    if (s > 255) begin m8_ovf = 1'b1; m8_acc = SAT ? 255 : (s & 255); end
    else m8_acc = s;
  endtask

  task automatic push_expected;
    q_data.push_back(m_acc);  q_ovf.push_back(m_ovf);
    q8_data.push_back(m8_acc); q8_ovf.push_back(m8_ovf);
  endtask

  task automatic do_start(input int l);
    start = 1'b1; len = 8'(l);
    tick;
    start = 1'b0;
    m_acc = 0; m8_acc = 0; m_ovf = 1'b0; m8_ovf = 1'b0;
    if (l == 0) push_expected();
  endtask

  task automatic send(input int d, input int gap, input bit last);
    in_valid = 1'b1; in_data = 5'(d);
    tick;
    in_valid = 1'b0;
    model_add(d);
    if (last) push_expected();
    repeat (gap) begin
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL gap_in_ready got %0b want 1", in_ready); end
      tick;
    end
  endtask

  // Waits for out_valid, compares against scoreboard, completes the handshake.
  task automatic wait_out(input string name);
    int exp_d, exp8_d;
    bit exp_o, exp8_o;
    for (int i = 0; i < 50 && out_valid !== 1'b1; i++) tick;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_timeout out_valid got %0b want 1", name, out_valid); end
    checks++;
    if (q_data.size() == 0) begin
      errors++; $display("FAIL %s_scoreboard_empty got 0 entries want 1", name);
    end else begin
      exp_d = q_data.pop_front(); exp_o = q_ovf.pop_front();
      exp8_d = q8_data.pop_front(); exp8_o = q8_ovf.pop_front();
      if (out_data !== 12'(exp_d) || overflow !== exp_o) begin
        errors++; $display("FAIL %s_data got %0d/%0b want %0d/%0b", name, out_data, overflow, exp_d, exp_o);
      end
      checks++;
      if (out_valid8 !== 1'b1 || out_data8 !== 8'(exp8_d) || overflow8 !== exp8_o) begin
        errors++; $display("FAIL %s_data8 got v%0b %0d/%0b want v1 %0d/%0b", name, out_valid8, out_data8, overflow8, exp8_d, exp8_o);
      end
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_idle got v%0b b%0b want v0 b0", name, out_valid, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    checks++;
    if ({out_valid, in_ready, busy, overflow} !== 4'b0 || out_data !== 12'd0) begin
      errors++; $display("FAIL reset got v%0b r%0b b%0b o%0b d%0d want all 0", out_valid, in_ready, busy, overflow, out_data);
    end
  endtask

  task automatic test_back_to_back;
    do_start(4);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_accum got b%0b r%0b want b1 r1", busy, in_ready); end
    send(5, 0, 0); send(10, 0, 0); send(31, 0, 0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid got %0b want 0", out_valid); end
    send(1, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== 12'd47) begin
      errors++; $display("FAIL b2b_latency got v%0b b%0b d%0d want v1 b1 d47", out_valid, busy, out_data);
    end
    wait_out("b2b");
  endtask

  task automatic test_gaps_and_backpressure;
    do_start(4);
    send(5, 2, 0); send(10, 2, 0); send(31, 2, 0); send(1, 0, 1);
    in_valid = 1'b1; in_data = 5'd9;
    repeat (3) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || out_data !== 12'd47) begin
        errors++; $display("FAIL hold_stable got v%0b r%0b b%0b d%0d want v1 r0 b1 d47", out_valid, in_ready, busy, out_data);
      end
      tick;
    end
    in_valid = 1'b0;
    wait_out("gaps");
  endtask

  task automatic test_overflow;
    do_start(9);
    for (int i = 0; i < 9; i++) send(31, 0, i == 8);
    checks++;
    if (out_data8 !== (SAT ? 8'd255 : 8'd23) || overflow8 !== 1'b1 || out_data !== 12'd279 || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_direct got %0d/%0b %0d/%0b want %0d/1 279/0", out_data8, overflow8, out_data, overflow, SAT ? 255 : 23);
    end
    wait_out("ovf");
  endtask

  task automatic test_len_zero;
    do_start(0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 12'd0 || overflow !== 1'b0 || overflow8 !== 1'b0) begin
      errors++; $display("FAIL len0 got v%0b d%0d o%0b o8%0b want v1 d0 o0 o80", out_valid, out_data, overflow, overflow8);
    end
    wait_out("len0");
    do_start(1);
    send(7, 0, 1);
    wait_out("len1");
  endtask

  task automatic test_mid_reset;
    do_start(4);
    send(20, 0, 0); send(30, 0, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b0 || out_data !== 12'd0) begin
      errors++; $display("FAIL mid_reset got v%0b r%0b b%0b d%0d want all 0", out_valid, in_ready, busy, out_data);
    end
    do_start(2);
    send(3, 0, 0); send(4, 0, 1);
    wait_out("after_reset");
  endtask

  task automatic test_start_ignored;
    do_start(3);
    send(9, 0, 0);
    start = 1'b1; len = 8'd2;
    tick;
    start = 1'b0;
    send(8, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL restart_ignored got v%0b r%0b want v0 r1", out_valid, in_ready);
    end
    send(20, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 12'd37) begin
      errors++; $display("FAIL restart_total got v%0b d%0d want v1 d37", out_valid, out_data);
    end
    wait_out("restart");
  endtask

  task automatic test_start_on_handshake;
    do_start(1);
    send(6, 0, 1);
    checks++;
    if (out_data !== 12'd6) begin errors++; $display("FAIL hs_data got %0d want 6", out_data); end
    void'(q_data.pop_front()); void'(q_ovf.pop_front());
    void'(q8_data.pop_front()); void'(q8_ovf.pop_front());
    out_ready = 1'b1; start = 1'b1; len = 8'd3;
    tick;
    out_ready = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_data !== 12'd6) begin
      errors++; $display("FAIL hs_start_ignored got b%0b r%0b d%0d want b0 r0 d6", busy, in_ready, out_data);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    m_acc = 0; m8_acc = 0; m_ovf = 1'b0; m8_ovf = 1'b0;
    test_reset();
    test_back_to_back();
    test_gaps_and_backpressure();
    test_overflow();
    test_len_zero();
    test_mid_reset();
    test_start_ignored();
    test_start_on_handshake();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
